// File: rtl/mips_pkg.sv
// Shared pipeline types: memory-stage FSM states, width defaults and the
// MEM/WB control bundle.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctl_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding data-memory transaction; expired
// marks the last permitted cycle of the transaction.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt;

    assign expired = enable & (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: runs the dmem req/ack handshake for loads and stores, stalls
// upstream while it is outstanding, and registers the MEM/WB bundle.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_W-1:0]  rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_alu,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              timeout_err
);

    mem_state_t       state;
    wb_ctl_t          lat_ctl;
    wb_ctl_t          wb_ctl;
    logic [REG_W-1:0] lat_rd;
    logic             in_access;
    logic             accept;
    logic             is_mem;
    logic             expired;

    assign in_access   = (state == S_ACCESS);
    assign accept      = valid_in & ~flush;
    assign is_mem      = MemRead | MemWrite;

    // Request comes straight from state so an async reset drops it at once.
    assign dmem_req    = in_access;
    assign stall       = in_access & ~dmem_ack;
    assign wb_RegWrite = wb_ctl.reg_write;
    assign wb_MemtoReg = wb_ctl.mem_to_reg;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (~in_access),
        .enable  (in_access),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            lat_rd      <= '0;
            lat_ctl     <= '0;
            wb_valid    <= 1'b0;
            wb_ctl      <= '0;
            wb_rd       <= '0;
            wb_alu      <= '0;
            wb_mem_data <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_mem) begin
                        state      <= S_ACCESS;
                        dmem_we    <= MemWrite;
                        dmem_addr  <= alu_result;
                        dmem_wdata <= write_data;
                        lat_rd     <= rd;
                        lat_ctl    <= '{reg_write: RegWrite, mem_to_reg: MemtoReg};
                        wb_valid   <= 1'b0;
                        wb_ctl     <= '0;
                    end else if (accept) begin
                        wb_valid    <= 1'b1;
                        wb_ctl      <= '{reg_write: RegWrite, mem_to_reg: MemtoReg};
                        wb_rd       <= rd;
                        wb_alu      <= alu_result;
                        wb_mem_data <= '0;
                    end else begin
                        wb_valid <= 1'b0;
                        wb_ctl   <= '0;
                    end
                end
                S_ACCESS: begin
                    // Ack takes priority over an expiry in the same cycle.
                    if (dmem_ack) begin
                        state       <= S_IDLE;
                        wb_valid    <= 1'b1;
                        wb_ctl      <= lat_ctl;
                        wb_rd       <= lat_rd;
                        wb_alu      <= dmem_addr;
                        wb_mem_data <= dmem_we ? '0 : dmem_rdata;
                    end else if (expired) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        wb_valid    <= 1'b0;
                        wb_ctl      <= '0;
                    end else begin
                        wb_valid <= 1'b0;
                        wb_ctl   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed checks of mem_stage against a transaction-level
// reference kept in the bench.
module tb_mem_stage;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, flush, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [31:0] alu_result, write_data, dmem_rdata;
    logic [4:0]  rd;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, wb_valid, wb_RegWrite, wb_MemtoReg, timeout_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_alu, wb_mem_data;
    logic [4:0]  wb_rd;

    int checks = 0;
    int errors = 0;
    int req_cnt, stall_cnt;

    // Reference: one pending transaction plus the last retired WB bundle.
    bit          m_busy;
    int          m_wait;
    bit          m_we, m_rw, m_m2r, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    bit          e_valid, e_rw, e_m2r;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_md;

    mem_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .alu_result(alu_result), .write_data(write_data), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_rd(wb_rd), .wb_alu(wb_alu), .wb_mem_data(wb_mem_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_wait = 0; m_we = 0; m_rw = 0; m_m2r = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_rd = 0;
        e_valid = 0; e_rw = 0; e_m2r = 0; e_rd = 0; e_alu = 0; e_md = 0;
    endtask

    task automatic compare();
        chk("dmem_req", {31'b0, dmem_req}, {31'b0, m_busy});
        chk("stall", {31'b0, stall}, {31'b0, m_busy & ~dmem_ack});
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_we});
        chk("dmem_addr", dmem_addr, m_addr);
        chk("dmem_wdata", dmem_wdata, m_wdata);
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, e_valid});
        chk("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, e_rw});
        chk("wb_MemtoReg", {31'b0, wb_MemtoReg}, {31'b0, e_m2r});
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
        chk("wb_alu", wb_alu, e_alu);
        chk("wb_mem_data", wb_mem_data, e_md);
        chk("timeout_err", {31'b0, timeout_err}, {31'b0, m_err});
    endtask

    // Outcome of one clock edge given the inputs held during the cycle.
    task automatic m_edge();
        e_valid = 0; e_rw = 0; e_m2r = 0;
        if (!m_busy) begin
            if (valid_in && !flush && (MemRead || MemWrite)) begin
                m_busy = 1; m_wait = 0; m_we = MemWrite;
                m_addr = alu_result; m_wdata = write_data; m_rd = rd;
                m_rw = RegWrite; m_m2r = MemtoReg;
            end else if (valid_in && !flush) begin
                e_valid = 1; e_rw = RegWrite; e_m2r = MemtoReg;
                e_rd = rd; e_alu = alu_result; e_md = 0;
            end
        end else if (dmem_ack) begin
            m_busy = 0;
            e_valid = 1; e_rw = m_rw; e_m2r = m_m2r;
            e_rd = m_rd; e_alu = m_addr; e_md = m_we ? 32'h0 : dmem_rdata;
        end else if (m_wait + 1 == TO) begin
            m_busy = 0; m_err = 1;
        end else begin
            m_wait++;
        end
    endtask

    task automatic step(input bit v, input bit fl, input bit mr, input bit mw,
                        input bit m2r, input bit rw, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] r,
                        input bit ack, input logic [31:0] rdata);
        @(negedge clk);
        valid_in = v; flush = fl; MemRead = mr; MemWrite = mw; MemtoReg = m2r;
        RegWrite = rw; alu_result = alu; write_data = wd; rd = r;
        dmem_ack = ack; dmem_rdata = rdata;
        #1;
        compare();
        if (dmem_req) req_cnt++;
        if (stall) stall_cnt++;
        @(posedge clk);
        #1;
        m_edge();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
    endtask

    initial begin
        rst_n = 0;
        valid_in = 0; flush = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        alu_result = 0; write_data = 0; rd = 0; dmem_ack = 0; dmem_rdata = 0;
        m_reset();
        #1;
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("rst_wb_alu", wb_alu, 32'd0);
        #20 rst_n = 1;

        // ALU pass-through
        req_cnt = 0; stall_cnt = 0;
        step(1, 0, 0, 0, 0, 1, 32'h1234, 32'h0, 5'd7, 0, 32'h0);
        chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("alu_wb_rd", {27'b0, wb_rd}, 32'd7);
        chk("alu_wb_alu", wb_alu, 32'h1234);
        chk("alu_wb_mem_data", wb_mem_data, 32'h0);
        idle();
        chk("alu_stall_cycles", stall_cnt, 32'd0);

        // Load, ack on the 4th request cycle
        req_cnt = 0; stall_cnt = 0;
        step(1, 0, 1, 0, 1, 1, 32'h100, 32'h0, 5'd3, 0, 32'h0);
        for (int i = 0; i < 3; i++) idle();
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hDEADBEEF);
        chk("ld_req_cycles", req_cnt, 32'd4);
        chk("ld_stall_cycles", stall_cnt, 32'd3);
        chk("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("ld_wb_MemtoReg", {31'b0, wb_MemtoReg}, 32'd1);
        chk("ld_wb_mem_data", wb_mem_data, 32'hDEADBEEF);
        chk("ld_wb_alu", wb_alu, 32'h100);

        // Zero-wait store
        req_cnt = 0; stall_cnt = 0;
        step(1, 0, 0, 1, 0, 0, 32'h200, 32'h55, 5'd9, 0, 32'h0);
        chk("st_dmem_we", {31'b0, dmem_we}, 32'd1);
        chk("st_wb_valid_bubble", {31'b0, wb_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hFFFF);
        chk("st_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("st_wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
        chk("st_wb_mem_data", wb_mem_data, 32'h0);
        chk("st_stall_cycles", stall_cnt, 32'd0);

        // Timeout, then an ALU instruction still retires
        req_cnt = 0;
        step(1, 0, 1, 0, 1, 1, 32'h300, 32'h0, 5'd4, 0, 32'h0);
        for (int i = 0; i < TO; i++) idle();
        chk("to_req_cycles", req_cnt, TO);
        chk("to_err", {31'b0, timeout_err}, 32'd1);
        chk("to_wb_valid", {31'b0, wb_valid}, 32'd0);
        step(1, 0, 0, 0, 0, 1, 32'h77, 32'h0, 5'd2, 0, 32'h0);
        chk("to_alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("to_err_held", {31'b0, timeout_err}, 32'd1);

        // Flush in IDLE, then flush ignored in ACCESS
        step(1, 1, 1, 0, 1, 1, 32'h400, 32'h0, 5'd5, 0, 32'h0);
        chk("fl_idle_req", {31'b0, dmem_req}, 32'd0);
        chk("fl_idle_wb_valid", {31'b0, wb_valid}, 32'd0);
        step(1, 0, 1, 0, 1, 1, 32'h500, 32'h0, 5'd6, 0, 32'h0);
        step(1, 1, 0, 0, 0, 1, 32'h999, 32'h0, 5'd1, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'hCAFE);
        chk("fl_acc_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("fl_acc_wb_rd", {27'b0, wb_rd}, 32'd6);

        // Reset mid-access
        step(1, 0, 1, 0, 1, 1, 32'h600, 32'h0, 5'd8, 0, 32'h0);
        @(negedge clk);
        valid_in = 0; dmem_ack = 0;
        #2 rst_n = 0;
        #1;
        chk("rm_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rm_stall", {31'b0, stall}, 32'd0);
        chk("rm_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rm_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rm_timeout_err", {31'b0, timeout_err}, 32'd0);
        m_reset();
        @(negedge clk);
        #2 rst_n = 1;
        step(1, 0, 0, 0, 0, 1, 32'hABC, 32'h0, 5'd11, 0, 32'h0);
        chk("rm_alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("rm_alu_wb_alu", wb_alu, 32'hABC);

        // Randomized traffic
        begin
            int plan;
            plan = 0;
            for (int n = 0; n < 400; n++) begin
                bit v, fl, mr, mw, ack;
                if (!m_busy) plan = $urandom_range(0, TO + 1);
                v   = ($urandom_range(0, 3) != 0);
                fl  = ($urandom_range(0, 7) == 0);
                mr  = $urandom_range(0, 1);
                mw  = ($urandom_range(0, 2) == 0);
                ack = m_busy && (m_wait == plan);
                step(v, fl, mr, mw, $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom, $urandom, 5'($urandom), ack, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
